syn_seg_display: RTL and testbench

SYN_SEG_DISPLAY -- requirements
Module: syn_seg_display

---
 rtl/syn_seg_display.sv | 159 +++++++++++++++
 tb/tb_syn_seg_display.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/syn_seg_display.sv
// Eight-digit multiplexed 7-segment driver for CPU debug values. Latches the
// selected source once per frame and blinks the whole display after a halt.
module syn_seg_display #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  sel,
    input  logic [31:0] data_disp,
    input  logic [31:0] data_pc,
    input  logic [31:0] data_rf,
    input  logic [31:0] data_dm,
    input  logic        halted,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        frame_tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [2:0]       digit_reg, digit_next;
    logic [31:0]      shadow_reg, shadow_next;
    logic             halt_latch_reg, halt_latch_next;
    logic             blink_on_reg, blink_on_next;
    logic [FRM_W-1:0] frm_cnt_reg, frm_cnt_next;
    logic [7:0]       an_reg, an_next;
    logic [7:0]       seg_reg, seg_next;
    logic             frame_tick_reg, frame_tick_next;

    logic        slot_adv;
    logic        frame_wrap;
    logic [31:0] src_sel;
    logic [3:0]  nibble;
    logic [6:0]  hex7;
    logic [7:0]  lz_blank;
    logic [7:0]  an_onehot;
    logic        digit_dark;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_adv   = en && (div_reg == DIV_LAST);
    assign frame_wrap = slot_adv && (digit_reg == 3'd7);

    always_comb begin
        case (sel)
            2'd0:    src_sel = data_disp;
            2'd1:    src_sel = data_pc;
            2'd2:    src_sel = data_rf;
            default: src_sel = data_dm;
        endcase
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    assign lz_blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_lz
            assign lz_blank[gi] = (shadow_reg[31:4*gi] == '0);
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_an
            assign an_onehot[gi] = (digit_reg != 3'(gi));
        end
    endgenerate

    assign nibble     = shadow_reg[{digit_reg, 2'b00} +: 4];
    assign hex7       = hex_seg(nibble);
    assign digit_dark = !blink_on_reg || (blank_lz && lz_blank[digit_reg]);

    always_comb begin
        div_next        = div_reg;
        digit_next      = digit_reg;
        shadow_next     = shadow_reg;
        halt_latch_next = halt_latch_reg;
        blink_on_next   = blink_on_reg;
        frm_cnt_next    = frm_cnt_reg;
        frame_tick_next = frame_wrap;

        if (en) begin
            div_next = slot_adv ? '0 : div_reg + DIV_W'(1);
        end
        if (slot_adv) begin
            digit_next = digit_reg + 3'd1;
        end
        if (frame_wrap) begin
            shadow_next     = src_sel;
            halt_latch_next = halt_latch_reg | halted;
        end
        // Blinking only starts counting frames once the halt was already latched.
        if (frame_wrap && halt_latch_reg) begin
            if (frm_cnt_reg == FRM_LAST) begin
                frm_cnt_next  = '0;
                blink_on_next = !blink_on_reg;
            end else begin
                frm_cnt_next = frm_cnt_reg + FRM_W'(1);
            end
        end

        an_next  = digit_dark ? 8'hFF : an_onehot;
        seg_next = {!(halt_latch_reg && (digit_reg == 3'd0)), hex7};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg        <= '0;
            digit_reg      <= 3'd0;
            shadow_reg     <= 32'd0;
            halt_latch_reg <= 1'b0;
            blink_on_reg   <= 1'b1;
            frm_cnt_reg    <= '0;
            an_reg         <= 8'hFE;
            seg_reg        <= 8'hC0;
            frame_tick_reg <= 1'b0;
        end else begin
            div_reg        <= div_next;
            digit_reg      <= digit_next;
            shadow_reg     <= shadow_next;
            halt_latch_reg <= halt_latch_next;
            blink_on_reg   <= blink_on_next;
            frm_cnt_reg    <= frm_cnt_next;
            frame_tick_reg <= frame_tick_next;
            if (en) begin
                an_reg  <= an_next;
                seg_reg <= seg_next;
            end
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_syn_seg_display.sv
// Directed bench for syn_seg_display with a fast scan (4 cycles/slot, 2-frame blink).
module tb_syn_seg_display;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  sel;
    logic [31:0] data_disp, data_pc, data_rf, data_dm;
    logic        halted;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        frame_tick;

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] sb_q[$];

    syn_seg_display #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel),
        .data_disp(data_disp), .data_pc(data_pc), .data_rf(data_rf), .data_dm(data_dm),
        .halted(halted), .blank_lz(blank_lz),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [7:0] v;
        case (nib)
            4'h0: v = 8'hC0; 4'h1: v = 8'hF9; 4'h2: v = 8'hA4; 4'h3: v = 8'hB0;
            4'h4: v = 8'h99; 4'h5: v = 8'h92; 4'h6: v = 8'h82; 4'h7: v = 8'hF8;
            4'h8: v = 8'h80; 4'h9: v = 8'h90; 4'hA: v = 8'h88; 4'hB: v = 8'h83;
            4'hC: v = 8'hC6; 4'hD: v = 8'hA1; 4'hE: v = 8'h86; default: v = 8'h8E;
        endcase
        return v[6:0];
    endfunction

    // Expected {an, seg} for digit d of a frame showing sh.
    function automatic logic [15:0] model(input logic [31:0] sh, input int d,
                                          input bit blank, input bit halt, input bit on);
        logic [31:0] upper;
        logic [7:0]  a;
        logic [7:0]  s;
        upper = sh >> (4 * d);
        s = {~(halt && d == 0), hex7(upper[3:0])};
        a = ~(8'h01 << d);
        if (!on || (blank && d >= 1 && upper == 32'd0)) a = 8'hFF;
        return {a, s};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] sh, input bit blank, input bit halt, input bit on);
        for (int d = 0; d < 8; d++) sb_q.push_back(model(sh, d, blank, halt, on));
    endtask

    task automatic sb_check(input string tag);
        logic [15:0] exp;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard required entry", tag);
        end else begin
            exp = sb_q.pop_front();
            check_val(tag, {24'd0, an, seg}, {16'd0, exp});
            $display("%s: an=%h seg=%h exp=%h", tag, an, seg, exp);
        end
    endtask

    // Called at the negedge where frame_tick is seen; samples each slot mid-way.
    task automatic check_frame(input string tag, input int swap_at, input logic [1:0] new_sel);
        for (int d = 0; d < 8; d++) begin
            repeat ((d == 0) ? 1 : 4) tick();
            if (d == 0) check_val({tag, "_tick_low"}, {31'd0, frame_tick}, 32'd0);
            sb_check($sformatf("%s_d%0d", tag, d));
            if (d == swap_at) sel = new_sel;
        end
    endtask

    task automatic wait_frame(input string tag, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (frame_tick !== 1'b1 && cycles < 200);
        check_val({tag, "_tick_seen"}, {31'd0, frame_tick}, 32'd1);
    endtask

    initial begin
        int c;
        rst = 1'b1; en = 1'b0; sel = 2'd0; halted = 1'b0; blank_lz = 1'b0;
        data_disp = 32'h1234ABCD; data_pc = 32'd0; data_rf = 32'hDEADBEEF; data_dm = 32'h0;

        // Reset must work with en low.
        repeat (3) tick();
        check_val("rst_an", {24'd0, an}, 32'hFE);
        check_val("rst_seg", {24'd0, seg}, 32'hC0);
        check_val("rst_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0; en = 1'b1;

        wait_frame("first", c);
        check_val("first_period", c, 32);
        wait_frame("second", c);
        check_val("frame_period", c, 32);
        push_frame(32'h1234ABCD, 0, 0, 1);
        check_frame("hex", -1, 2'd0);

        // Leading-zero blanking.
        data_disp = 32'h000000F0; blank_lz = 1'b1;
        wait_frame("lz", c);
        push_frame(32'h000000F0, 1, 0, 1);
        check_frame("lz", -1, 2'd0);

        // Source change mid-frame only takes effect on the next frame.
        blank_lz = 1'b0; data_disp = 32'h89ABCDEF; data_pc = 32'h00400000;
        wait_frame("pre_sel", c);
        push_frame(32'h89ABCDEF, 0, 0, 1);
        check_frame("old_src", 3, 2'd1);
        wait_frame("new_sel", c);
        push_frame(32'h00400000, 0, 0, 1);
        check_frame("new_src", -1, 2'd1);

        // Freeze one cycle into digit 4, then confirm the slot finishes exactly.
        wait_frame("frz", c);
        repeat (17) tick();
        en = 1'b0;
        sb_q.push_back(model(32'h00400000, 4, 0, 0, 1));
        tick();
        sb_check("frz_start");
        repeat (9) tick();
        sb_q.push_back(model(32'h00400000, 4, 0, 0, 1));
        sb_check("frz_end");
        check_val("frz_tick", {31'd0, frame_tick}, 32'd0);
        en = 1'b1;
        repeat (3) tick();
        sb_q.push_back(model(32'h00400000, 4, 0, 0, 1));
        sb_check("resume_d4");
        tick();
        sb_q.push_back(model(32'h00400000, 5, 0, 0, 1));
        sb_check("resume_d5");

        // Halt: dp on digit 0, display on 2 frames, off 2 frames, sticky.
        halted = 1'b1;
        wait_frame("halt_a", c);
        push_frame(32'h00400000, 0, 1, 1);
        check_frame("halt_a", -1, 2'd1);
        halted = 1'b0;
        wait_frame("halt_b", c);
        push_frame(32'h00400000, 0, 1, 1);
        check_frame("halt_b", -1, 2'd1);
        wait_frame("halt_c", c);
        push_frame(32'h00400000, 0, 1, 0);
        check_frame("halt_c", -1, 2'd1);
        wait_frame("halt_d", c);
        push_frame(32'h00400000, 0, 1, 0);
        check_frame("halt_d", -1, 2'd1);
        wait_frame("halt_e", c);
        push_frame(32'h00400000, 0, 1, 1);
        check_frame("halt_e", -1, 2'd1);

        // Reset in the middle of digit 5.
        wait_frame("pre_rst", c);
        repeat (21) tick();
        sb_q.push_back(model(32'h00400000, 5, 0, 1, 1));
        sb_check("pre_rst_d5");
        tick();
        rst = 1'b1;
        tick();
        check_val("mid_rst_an", {24'd0, an}, 32'hFE);
        check_val("mid_rst_seg", {24'd0, seg}, 32'hC0);
        check_val("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;
        repeat (21) tick();
        sb_q.push_back(model(32'h00000000, 5, 0, 0, 1));
        sb_check("post_rst_shadow0");
        wait_frame("post_rst", c);
        check_val("post_rst_period", c, 11);
        push_frame(32'h00400000, 0, 0, 1);
        check_frame("post_rst", -1, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
